// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register, ready-handshaked fetch, IR field decode and next-PC select.
// Optional retired-instruction counter enabled by defining IFU_ICOUNT_EN.
module ifu_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [1:0]        PCSel,
  input  logic [31:0]       ExtImm,
  output logic              IMemReq,
  output logic [ADDR_W-1:0] IMemAddr,
  input  logic              IMemRdy,
  input  logic [31:0]       IMemData,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PC4,
  output logic [31:0]       Instr,
  output logic [5:0]        Op,
  output logic [5:0]        Func,
  output logic [4:0]        Rs,
  output logic [4:0]        Rt,
  output logic [4:0]        Rd,
  output logic [4:0]        Sa,
  output logic [15:0]       Imm16,
  output logic              InsValid,
  output logic              Halted,
  output logic [31:0]       InsCount
);

  // state   | meaning
  // S_REQ   | request held on IMemAddr until IMemRdy
  // S_EXEC  | IR valid for one cycle, PCSel sampled at closing edge
  // S_HALTED| HALT retired, only nRST leaves
  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_EXEC   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [1:0] SEL_NEXT = 2'b00;
  localparam logic [1:0] SEL_REL  = 2'b01;
  localparam logic [1:0] SEL_ABS  = 2'b10;

  state_t            state_q;
  logic              req_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc4;
  logic [31:0]       ir_q;

  assign pc4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_q;
    unique case (PCSel)
      SEL_NEXT: pc_d = pc4;
      SEL_REL:  pc_d = pc4 + (ExtImm << 2);
      SEL_ABS:  pc_d = {pc4[31:28], ir_q[25:0], 2'b00};
      default:  pc_d = pc_q;
    endcase
  end

  // req_q is registered so IMemReq reads 0 in reset; the first fetch after
  // reset therefore spends one extra cycle in S_REQ before the request rises.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_REQ;
      req_q   <= 1'b0;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (req_q && IMemRdy) begin
            ir_q    <= IMemData;
            req_q   <= 1'b0;
            state_q <= S_EXEC;
          end else begin
            req_q   <= 1'b1;
          end
        end
        S_EXEC: begin
          pc_q <= pc_d;
          if (PCSel == 2'b11) begin
            state_q <= S_HALTED;
          end else begin
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_HALTED: begin
          req_q <= 1'b0;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= S_REQ;
        end
      endcase
    end
  end

`ifdef IFU_ICOUNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else if (state_q == S_EXEC) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign InsCount = cnt_q;
`else
  assign InsCount = '0;
`endif

  assign IMemReq  = req_q;
  assign IMemAddr = pc_q;
  assign PC       = pc_q;
  assign PC4      = pc4;
  assign Instr    = ir_q;
  assign Op       = ir_q[31:26];
  assign Func     = ir_q[5:0];
  assign Rs       = ir_q[25:21];
  assign Rt       = ir_q[20:16];
  assign Rd       = ir_q[15:11];
  assign Sa       = ir_q[10:6];
  assign Imm16    = ir_q[15:0];
  assign InsValid = (state_q == S_EXEC);
  assign Halted   = (state_q == S_HALTED);

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit directly upstream of the control unit.
- Holds the PC and fetches each instruction over a ready-handshaked instruction-memory port.
- Presents decoded fields (Op, Func, rs, rt, rd, sa, imm16) to the control unit and datapath.
- Consumes the control unit's PCSel to compute the next PC, and stops permanently on HALT.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width; fixed at 32 for this design, kept for bench readability.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- PCSel  in  2  next-PC select from control unit: 00 NextIns, 01 RelJmp, 10 AbsJmp, 11 HALT.
- ExtImm  in  32  extended immediate from the extender; branch offset in words.
- IMemReq  out  1  fetch request.
- IMemAddr  out  32  fetch address, equal to PC.
- IMemRdy  in  1  memory has valid data on IMemData this cycle.
- IMemData  in  32  fetched instruction word.
- PC  out  32  current PC.
- PC4  out  32  PC+4.
- Instr  out  32  instruction register (IR).
- Op  out  6  IR[31:26].
- Func  out  6  IR[5:0].
- Rs  out  5  IR[25:21].
- Rt  out  5  IR[20:16].
- Rd  out  5  IR[15:11].
- Sa  out  5  IR[10:6].
- Imm16  out  16  IR[15:0].
- InsValid  out  1  IR holds an executing instruction this cycle.
- Halted  out  1  HALT has retired; sticky.
- InsCount  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (asynchronous, nRST=0): PC=PC_RESET, IR=0, state=REQ.
- Reset values of outputs: IMemReq=0, InsValid=0, Halted=0, InsCount=0.
- Reset takes effect immediately. A mid-fetch request is abandoned, and an IMemRdy arriving during reset is ignored.
- FSM states: REQ, EXEC, HALTED. All outputs are registered or decoded directly from state/IR/PC; there is no combinational path from IMemRdy to outputs.
- REQ:
  - IMemReq=1, IMemAddr=PC.
  - Request is held stable until IMemRdy=1.
  - On an edge with IMemRdy=1: IR<=IMemData, go to EXEC.
  - Zero-wait memory (IMemRdy already high) means a 1-cycle REQ.
- EXEC:
  - InsValid=1 for exactly one cycle; IMemReq=0.
  - The control unit and datapath evaluate combinationally this cycle; PCSel is sampled at the closing edge.
  - PCSel=00: PC<=PC4, go to REQ.
  - PCSel=01: PC<=PC4+(ExtImm<<2), go to REQ.
  - PCSel=10: PC<={PC4[31:28], IR[25:0], 2'b00}, go to REQ.
  - PCSel=11: PC unchanged, go to HALTED.
- HALTED:
  - IMemReq=0, InsValid=0, Halted=1.
  - PC and IR hold their last values.
  - Only nRST exits this state.
- IMemRdy outside REQ is ignored.
- Arithmetic:
  - All PC arithmetic is modulo 2^32; PC4 of 32'hFFFF_FFFC is 0.
  - Negative ExtImm branches backwards, two's complement.
  - The low 2 PC bits are never forced; a misaligned PC_RESET propagates.
- Throughput: each instruction takes (REQ cycles)+1 cycles; minimum 2 cycles per instruction.
- PCSel is ignored outside EXEC.

Optional Feature:
- Macro: IFU_ICOUNT_EN.
- Defined:
  - InsCount increments by 1 at each EXEC closing edge, including the HALT instruction.
  - Wraps from 32'hFFFF_FFFF to 0.
  - Cleared by reset; frozen in HALTED.
- Undefined: InsCount is constant 0 and no counter register exists.

Test Plan:
- Reset with PC_RESET=0 and zero-wait memory returning 32'h0000_0000 (NextIns) -> IMemAddr sequence 0,4,8; InsValid pulses every 2nd cycle; Op/Func decode correctly.
- IMemRdy delayed 3 cycles on the fetch at PC=0x10 -> IMemReq/IMemAddr=0x10 held 3 cycles; IR loaded only on the Rdy edge; spurious Rdy during EXEC ignored.
- At PC=0x20, PCSel=01 with ExtImm=32'hFFFF_FFFE -> next IMemAddr=0x1C. At PC=0x20, PCSel=01 with ExtImm=3 -> next IMemAddr=0x30.
- At PC=0x4000_0008 with IR[25:0]=26'h000_0010, PCSel=10 -> next IMemAddr=0x4000_0040.
- PCSel=11 in EXEC at PC=0x44 -> Halted=1, PC stays 0x44, no further IMemReq for 20 cycles. Then assert nRST low mid-cycle -> immediate PC=PC_RESET, Halted=0, IMemReq=0.
- With IFU_ICOUNT_EN: 5 instructions then HALT -> InsCount=6, unchanged afterwards. Without the macro: InsCount=0 throughout.
